// File: rtl/write_burst_master.sv
// rtl/write_burst_master.sv - Avalon-MM write burst master fed from a stream
// Splits a descriptor into bursts that never cross a MAX_BURST-beat aligned window.
module write_burst_master #(
    parameter int ADDRESS_WIDTH = 48,
    parameter int DATA_WIDTH    = 512,
    parameter int BURST_WIDTH   = 3,
    parameter int LENGTH_WIDTH  = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_address,
    input  logic [LENGTH_WIDTH-1:0]   cmd_beats,
    input  logic [DATA_WIDTH-1:0]     st_data,
    input  logic                      st_valid,
    output logic                      st_ready,
    output logic [ADDRESS_WIDTH-1:0]  m_address,
    output logic [DATA_WIDTH-1:0]     m_writedata,
    output logic                      m_write,
    output logic [DATA_WIDTH/8-1:0]   m_byteenable,
    output logic [BURST_WIDTH-1:0]    m_burst,
    input  logic                      m_waitrequest,
    input  logic [1:0]                m_response,
    input  logic                      m_write_response_valid,
    output logic                      done,
    output logic                      done_error,
    output logic                      busy
);
    localparam int BYTES       = DATA_WIDTH / 8;
    localparam int OFFSET_BITS = $clog2(BYTES);
    localparam int WIN_BITS    = BURST_WIDTH - 1;
    localparam int MAX_BURST   = 1 << WIN_BITS;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DRAIN, S_DONE} state_t;

    state_t                    r_state;
    logic [ADDRESS_WIDTH-1:0]  r_address;
    logic [BURST_WIDTH-1:0]    r_burst;
    logic [BURST_WIDTH-1:0]    r_burst_left;
    logic [LENGTH_WIDTH-1:0]   r_remaining;
    logic [LENGTH_WIDTH-1:0]   r_outstanding;
    logic                      r_error;
    logic                      r_done;
    logic                      r_done_error;

    logic [ADDRESS_WIDTH-1:0]  w_cmd_address;
    logic [ADDRESS_WIDTH-1:0]  w_next_address;
    logic [LENGTH_WIDTH-1:0]   w_remaining_dec;
    logic [BURST_WIDTH-1:0]    w_cmd_burst;
    logic [BURST_WIDTH-1:0]    w_next_burst;
    logic [LENGTH_WIDTH-1:0]   w_outstanding_next;
    logic                      w_beat;
    logic                      w_first;
    logic                      w_last_in_burst;
    logic                      w_final;
    logic                      w_resp;

    // Room left in the current window, clipped by the beats still owed.
    function automatic logic [BURST_WIDTH-1:0] f_burst_len(
        input logic [WIN_BITS-1:0]     idx,
        input logic [LENGTH_WIDTH-1:0] rem
    );
        logic [BURST_WIDTH-1:0] room;
        room = BURST_WIDTH'(MAX_BURST) - {1'b0, idx};
        if (rem < LENGTH_WIDTH'(room))
            f_burst_len = rem[BURST_WIDTH-1:0];
        else
            f_burst_len = room;
    endfunction

    assign w_cmd_address   = cmd_address & ~ADDRESS_WIDTH'(BYTES - 1);
    assign w_next_address  = r_address + (ADDRESS_WIDTH'(r_burst) << OFFSET_BITS);
    assign w_remaining_dec = r_remaining - LENGTH_WIDTH'(1);
    assign w_cmd_burst     = f_burst_len(w_cmd_address[OFFSET_BITS +: WIN_BITS], cmd_beats);
    assign w_next_burst    = f_burst_len(w_next_address[OFFSET_BITS +: WIN_BITS], w_remaining_dec);

    assign w_beat          = (r_state == S_WRITE) & st_valid & ~m_waitrequest;
    assign w_first         = w_beat & (r_burst_left == r_burst);
    assign w_last_in_burst = w_beat & (r_burst_left == BURST_WIDTH'(1));
    assign w_final         = w_beat & (r_remaining == LENGTH_WIDTH'(1));
    // Stray responses seen while idle belong to an abandoned descriptor.
    assign w_resp          = m_write_response_valid & (r_state != S_IDLE);

    always_comb begin
        w_outstanding_next = r_outstanding;
        if (w_first && !w_resp)
            w_outstanding_next = r_outstanding + LENGTH_WIDTH'(1);
        else if (!w_first && w_resp && r_outstanding != '0)
            w_outstanding_next = r_outstanding - LENGTH_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_address     <= '0;
            r_burst       <= '0;
            r_burst_left  <= '0;
            r_remaining   <= '0;
            r_outstanding <= '0;
            r_error       <= 1'b0;
            r_done        <= 1'b0;
            r_done_error  <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_done_error  <= 1'b0;
            r_outstanding <= w_outstanding_next;
            if (w_resp && m_response != 2'b00)
                r_error <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_address    <= w_cmd_address;
                        r_remaining  <= cmd_beats;
                        r_burst      <= w_cmd_burst;
                        r_burst_left <= w_cmd_burst;
                        r_error      <= 1'b0;
                        r_state      <= (cmd_beats != '0) ? S_WRITE : S_DONE;
                    end
                end
                S_WRITE: begin
                    if (w_beat) begin
                        r_remaining  <= w_remaining_dec;
                        r_burst_left <= r_burst_left - BURST_WIDTH'(1);
                        if (w_last_in_burst) begin
                            r_address    <= w_next_address;
                            r_burst      <= w_next_burst;
                            r_burst_left <= w_next_burst;
                        end
                        if (w_final)
                            r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_outstanding_next == '0)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done       <= 1'b1;
                    r_done_error <= r_error;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready    = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign m_write      = (r_state == S_WRITE) & st_valid;
    assign st_ready     = (r_state == S_WRITE) & ~m_waitrequest;
    assign m_writedata  = st_data;
    assign m_byteenable = '1;
    assign m_address    = r_address;
    assign m_burst      = r_burst;
    assign done         = r_done;
    assign done_error   = r_done_error;
endmodule

// File: tb/tb_write_burst_master.sv
// tb/tb_write_burst_master.sv - self-checking bench for write_burst_master
// Table-driven descriptors plus random ones, checked against a burst-splitting model.
module tb_write_burst_master;
    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [47:0]  cmd_address;
    logic [19:0]  cmd_beats;
    logic [511:0] st_data;
    logic         st_valid;
    logic         st_ready;
    logic [47:0]  m_address;
    logic [511:0] m_writedata;
    logic         m_write;
    logic [63:0]  m_byteenable;
    logic [2:0]   m_burst;
    logic         m_waitrequest;
    logic [1:0]   m_response;
    logic         m_write_response_valid;
    logic         done;
    logic         done_error;
    logic         busy;

    write_burst_master #(
        .ADDRESS_WIDTH(48), .DATA_WIDTH(512), .BURST_WIDTH(3), .LENGTH_WIDTH(20)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_address(cmd_address), .cmd_beats(cmd_beats),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .m_address(m_address), .m_writedata(m_writedata), .m_write(m_write),
        .m_byteenable(m_byteenable), .m_burst(m_burst),
        .m_waitrequest(m_waitrequest), .m_response(m_response),
        .m_write_response_valid(m_write_response_valid),
        .done(done), .done_error(done_error), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] addr;
        int          beats;
        bit          rnd;
        int          err_burst;
        int          exp_n;
        int          exp_first;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [47:0] addr;
        int          len;
    } burst_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          write_cycles;
    logic [31:0] data_seed;
    burst_t      exp_q[$];
    burst_t      obs_q[$];
    int          resp_due[$];
    logic [1:0]  resp_code[$];
    vec_t        tbl[8];
    vec_t        rv;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [511:0] beat_data(input int i);
        logic [511:0] d;
        for (int k = 0; k < 16; k++)
            d[k*32 +: 32] = (32'(i) * 32'h9E37_79B1) ^ data_seed ^ 32'(k << 24);
        return d;
    endfunction

    // Reference split: each burst fills at most to the next 4-beat (256-byte) boundary.
    task automatic build_model(input logic [47:0] addr, input int beats);
        logic [47:0] a;
        int rem, idx, len;
        exp_q.delete();
        a = addr & ~48'h3F;
        rem = beats;
        while (rem > 0) begin
            idx = int'((a / 64) % 4);
            len = (rem < 4 - idx) ? rem : 4 - idx;
            exp_q.push_back('{addr: a, len: len});
            a = a + 48'(len * 64);
            rem = rem - len;
        end
    endtask

    function automatic burst_t get_obs(input int i);
        burst_t b;
        b = '{addr: '1, len: -1};
        if (i < obs_q.size()) b = obs_q[i];
        return b;
    endfunction

    task automatic drive_idle();
        cmd_valid = 1'b0;
        st_valid = 1'b0;
        m_waitrequest = 1'b0;
        m_write_response_valid = 1'b0;
        m_response = 2'b00;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_cmd(input vec_t v);
        int beats_done, in_burst, burst_idx, proto_errs, beat_errs;
        int accept_cyc, last_resp_cyc, done_cyc, last_due, due;
        bit done_seen, got_err, phase;
        beats_done = 0; in_burst = 0; burst_idx = 0; proto_errs = 0; beat_errs = 0;
        last_resp_cyc = 0; done_cyc = -1; last_due = 0; done_seen = 0; got_err = 0;
        write_cycles = 0;
        data_seed = $urandom;
        obs_q.delete();
        resp_due.delete();
        resp_code.delete();
        build_model(v.addr, v.beats);

        drive_idle();
        cmd_valid = 1'b1;
        cmd_address = v.addr;
        cmd_beats = 20'(v.beats);
        #2;
        check("cmd_ready_idle", cmd_ready, 1);
        accept_cyc = cyc;
        next_cycle();
        cmd_valid = 1'b0;
        cmd_address = {16'($urandom), 32'($urandom)};

        for (int t = 0; t < 3000 && !done_seen; t++) begin
            if (v.rnd) begin
                st_valid = ($urandom_range(0, 3) != 0);
                m_waitrequest = ($urandom_range(0, 2) == 0);
            end else begin
                st_valid = 1'b1;
                m_waitrequest = 1'b0;
            end
            st_data = beat_data(beats_done);
            if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
                m_write_response_valid = 1'b1;
                m_response = resp_code.pop_front();
                void'(resp_due.pop_front());
                last_resp_cyc = cyc;
            end else begin
                m_write_response_valid = 1'b0;
                m_response = v.rnd ? 2'($urandom) : 2'b00;
            end
            #2;
            phase = (beats_done < v.beats);
            if (m_write !== (phase && st_valid)) proto_errs++;
            if (st_ready !== (phase && !m_waitrequest)) proto_errs++;
            if (busy !== !done || cmd_ready !== done) proto_errs++;
            if (m_byteenable !== '1) proto_errs++;
            if (m_write) begin
                write_cycles++;
                if (exp_q.size() == 0) beat_errs++;
                else if (m_address !== exp_q[0].addr || m_burst !== 3'(exp_q[0].len)) beat_errs++;
            end
            if (m_write && !m_waitrequest) begin
                if (m_writedata !== beat_data(beats_done)) beat_errs++;
                beats_done++;
                in_burst++;
                if (exp_q.size() > 0 && in_burst == exp_q[0].len) begin
                    obs_q.push_back('{addr: m_address, len: int'(m_burst)});
                    void'(exp_q.pop_front());
                    in_burst = 0;
                    due = cyc + (v.rnd ? int'($urandom_range(1, 6)) : 1);
                    if (resp_due.size() > 0 && due <= last_due) due = last_due + 1;
                    last_due = due;
                    resp_due.push_back(due);
                    resp_code.push_back((burst_idx == v.err_burst) ? 2'b10 : 2'b00);
                    burst_idx++;
                end
            end
            if (done) begin
                done_seen = 1;
                done_cyc = cyc;
                got_err = done_error;
            end
            next_cycle();
        end
        drive_idle();
        #2;
        check("done_pulse_width", done, 0);
        next_cycle();

        check("beats", beats_done, v.beats);
        check("bursts", obs_q.size(), v.exp_n);
        if (v.exp_n > 0) check("first_burst_len", get_obs(0).len, v.exp_first);
        check("protocol_violations", proto_errs, 0);
        check("beat_violations", beat_errs, 0);
        check("done_seen", done_seen, 1);
        check("done_cycle", done_cyc, (v.beats == 0) ? accept_cyc + 2 : last_resp_cyc + 2);
        check("done_error", got_err, v.exp_err);
    endtask

    initial begin
        tbl[0] = '{48'h0,              8,  1'b0, -1, 2,  4, 1'b0};
        tbl[1] = '{48'h80,             7,  1'b0, -1, 3,  2, 1'b0};
        tbl[2] = '{48'h1000,           37, 1'b1, -1, 10, 4, 1'b0};
        tbl[3] = '{48'h40,             9,  1'b1, 1,  3,  3, 1'b1};
        tbl[4] = '{48'h0,              0,  1'b0, -1, 0,  0, 1'b0};
        tbl[5] = '{48'hE3,             5,  1'b1, -1, 2,  1, 1'b0};
        tbl[6] = '{48'hFFFF_FFFF_FF00, 6,  1'b1, 0,  2,  4, 1'b1};
        tbl[7] = '{48'h200,            4,  1'b0, -1, 1,  4, 1'b0};

        reset = 1'b1;
        drive_idle();
        cmd_address = '0;
        cmd_beats = '0;
        st_data = '0;
        st_valid = 1'b1;
        next_cycle();
        next_cycle();
        #2;
        check("rst_m_write", m_write, 0);
        check("rst_st_ready", st_ready, 0);
        check("rst_done", done, 0);
        check("rst_done_error", done_error, 0);
        check("rst_busy", busy, 0);
        next_cycle();
        reset = 1'b0;
        drive_idle();
        #2;
        check("cmd_ready_after_reset", cmd_ready, 1);
        next_cycle();

        for (int i = 0; i < 7; i++) begin
            run_cmd(tbl[i]);
            if (i == 0) begin
                check("r0_b0_addr", get_obs(0).addr, 48'h0);
                check("r0_b1_addr", get_obs(1).addr, 48'h100);
                check("r0_b1_len", get_obs(1).len, 4);
                check("r0_write_cycles", write_cycles, 8);
            end
            if (i == 1) begin
                check("r1_b0_addr", get_obs(0).addr, 48'h80);
                check("r1_b1_addr", get_obs(1).addr, 48'h100);
                check("r1_b1_len", get_obs(1).len, 4);
                check("r1_b2_addr", get_obs(2).addr, 48'h200);
                check("r1_b2_len", get_obs(2).len, 1);
            end
            if (i == 4) check("zero_beats_write_cycles", write_cycles, 0);
        end

        // Reset in the middle of the first burst, then a stale error response.
        drive_idle();
        cmd_valid = 1'b1;
        cmd_address = 48'h0;
        cmd_beats = 20'd8;
        #2;
        next_cycle();
        cmd_valid = 1'b0;
        st_valid = 1'b1;
        st_data = '0;
        #2;
        next_cycle();
        #2;
        check("mid_burst_m_write", m_write, 1);
        next_cycle();
        reset = 1'b1;
        #2;
        next_cycle();
        reset = 1'b0;
        #2;
        check("post_reset_m_write", m_write, 0);
        check("post_reset_busy", busy, 0);
        check("post_reset_cmd_ready", cmd_ready, 1);
        check("post_reset_st_ready", st_ready, 0);
        next_cycle();
        st_valid = 1'b0;
        m_write_response_valid = 1'b1;
        m_response = 2'b10;
        #2;
        check("idle_response_busy", busy, 0);
        next_cycle();
        drive_idle();
        run_cmd(tbl[7]);

        for (int k = 0; k < 6; k++) begin
            rv.addr = {16'($urandom), 32'($urandom)};
            rv.beats = int'($urandom_range(1, 40));
            rv.rnd = 1'b1;
            if ($urandom_range(0, 1) == 1) rv.err_burst = int'($urandom_range(0, 5));
            else rv.err_burst = -1;
            build_model(rv.addr, rv.beats);
            rv.exp_n = exp_q.size();
            rv.exp_first = exp_q[0].len;
            rv.exp_err = (rv.err_burst >= 0 && rv.err_burst < rv.exp_n);
            run_cmd(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/write_burst_master.md
WRITE_BURST_MASTER -- requirements
Module: write_burst_master

Interface
REQ-001 SHALL have parameters: ADDRESS_WIDTH, 48, byte address width; DATA_WIDTH, 512, beat width; BURST_WIDTH, 3, 1+log2(MAX_BURST) with MAX_BURST a power of 2; LENGTH_WIDTH, 20, beat-count width.
REQ-002 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  descriptor valid.
- cmd_ready  out  1  descriptor accepted when cmd_valid & cmd_ready.
- cmd_address  in  ADDRESS_WIDTH  start byte address.
- cmd_beats  in  LENGTH_WIDTH  transfer length in beats.
- st_data  in  DATA_WIDTH  stream payload.
- st_valid  in  1  stream valid.
- st_ready  out  1  stream beat consumed when st_valid & st_ready.
- m_address  out  ADDRESS_WIDTH  Avalon-MM burst address.
- m_writedata  out  DATA_WIDTH  write data.
- m_write  out  1  write request.
- m_byteenable  out  DATA_WIDTH/8  byte enables.
- m_burst  out  BURST_WIDTH  burst count.
- m_waitrequest  in  1  backpressure.
- m_response  in  2  write response code.
- m_write_response_valid  in  1  one pulse per completed burst.
- done  out  1  one-cycle completion pulse.
- done_error  out  1  error status, valid with done.
- busy  out  1  descriptor in progress.

Function
REQ-003 SHALL implement states IDLE, WRITE, DRAIN, DONE.
REQ-004 SHALL assert cmd_ready only in IDLE; on acceptance, latch address with low log2(DATA_WIDTH/8) bits forced to zero, latch cmd_beats as remaining, clear error flag.
REQ-005 On acceptance with cmd_beats != 0, SHALL go to WRITE; with cmd_beats == 0, SHALL go to DONE, issuing no writes.
REQ-006 Burst length SHALL be min(MAX_BURST, remaining, MAX_BURST minus beat-index-within-MAX_BURST-window of the current address), so no burst crosses a MAX_BURST-beat aligned boundary.
REQ-007 m_address and m_burst SHALL be registered at the first beat of each burst and held constant for all beats of that burst.
REQ-008 In WRITE: m_write = st_valid; m_writedata = st_data; st_ready = ~m_waitrequest. A beat transfers when st_valid & ~m_waitrequest.
REQ-009 m_byteenable SHALL be all ones.
REQ-010 Each transferred beat SHALL decrement remaining by 1 and decrement the in-burst beat counter by 1.
REQ-011 When the last beat of a burst transfers, the address SHALL advance by burst*DATA_WIDTH/8, and the next burst length SHALL be computed per REQ-006.
REQ-012 An outstanding counter (LENGTH_WIDTH bits) SHALL increment on the first beat of each burst and decrement on m_write_response_valid; both in the same cycle SHALL leave it unchanged.
REQ-013 m_write_response_valid with m_response != 2'b00 SHALL set a sticky error flag.
REQ-014 When the final beat transfers, the block SHALL go to DRAIN.
REQ-015 In DRAIN, when outstanding == 0, including a response arriving that cycle that brings it to zero, the block SHALL go to DONE.
REQ-016 In DONE, the block SHALL assert done for one cycle with done_error = error flag, then return to IDLE.
REQ-017 busy SHALL be high in every state except IDLE.
REQ-018 st_ready SHALL be 0 and m_write SHALL be 0 outside WRITE.
REQ-019 Responses received while in IDLE SHALL be ignored and SHALL NOT underflow the counter.

Reset
REQ-020 On reset: state = IDLE; m_write, st_ready, done, done_error, busy = 0; cmd_ready = 1 from the first cycle after reset; outstanding, remaining, and burst counters = 0; error flag cleared.
REQ-021 Reset mid-transfer SHALL abandon the descriptor immediately; late responses after reset SHALL be ignored per REQ-019.

Verification
REQ-022 Bench SHALL cover: address 0x0, 8 beats, MAX_BURST=4, no stall -> two bursts, m_burst=4 at 0x0 and 0x100, 8 write cycles; after 2 OK responses, done=1, done_error=0.
REQ-023 Bench SHALL cover: address 0x80 (beat 2), 7 beats -> bursts of 2 @0x80, 4 @0x100, 1 @0x200.
REQ-024 Bench SHALL cover: random m_waitrequest and st_valid gaps, 37 beats -> exactly 37 data beats in order; m_address/m_burst stable within each burst; done only after the last response.
REQ-025 Bench SHALL cover: one response with m_response=2'b10 among 3 bursts -> done_error=1 on the done pulse.
REQ-026 Bench SHALL cover: cmd_beats=0 -> no m_write, done pulse 2 cycles after acceptance; also a response coincident with a burst start -> outstanding unchanged.
REQ-027 Bench SHALL cover: reset asserted mid-burst -> next cycle m_write=0, busy=0, cmd_ready=1.
